// File: rtl/gpr_file_mp_if.sv
// Register-file port bundle: read ports, two write lanes,
// pending-bit allocation and the registered write-trace stream.
interface gpr_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     w0_en;
  logic [ADDR_W-1:0]        w0_addr;
  logic [DATA_W-1:0]        w0_data;
  logic [31:0]              w0_pc;
  logic                     w1_en;
  logic [ADDR_W-1:0]        w1_addr;
  logic [DATA_W-1:0]        w1_data;
  logic [31:0]              w1_pc;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic [1:0]               trace_valid;
  logic [2*ADDR_W-1:0]      trace_addr;
  logic [2*DATA_W-1:0]      trace_data;
  logic [63:0]              trace_pc;

  modport master (
    output rd_addr,
    input  rd_data, rd_busy,
    output w0_en, w0_addr, w0_data, w0_pc,
    output w1_en, w1_addr, w1_data, w1_pc,
    output alloc_en, alloc_addr,
    input  trace_valid, trace_addr, trace_data, trace_pc
  );

  modport slave (
    input  rd_addr,
    output rd_data, rd_busy,
    input  w0_en, w0_addr, w0_data, w0_pc,
    input  w1_en, w1_addr, w1_data, w1_pc,
    input  alloc_en, alloc_addr,
    output trace_valid, trace_addr, trace_data, trace_pc
  );
endinterface

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: async reads, two prioritised write lanes,
// optional bypass, per-register pending bits and write trace.
module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  gpr_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic [1:0]          tr_valid_q, tr_valid_d;
  logic [2*ADDR_W-1:0] tr_addr_q, tr_addr_d;
  logic [2*DATA_W-1:0] tr_data_q, tr_data_d;
  logic [63:0]         tr_pc_q, tr_pc_d;

  logic w0_eff, w1_eff, alloc_eff;

  // Lane 1 wins a same-address collision, so lane 0 is squashed.
  assign w1_eff = bus.w1_en
                  && !(ZR && bus.w1_addr == '0);
  assign w0_eff = bus.w0_en
                  && !(ZR && bus.w0_addr == '0)
                  && !(bus.w1_en
                       && bus.w1_addr == bus.w0_addr);
  assign alloc_eff = bus.alloc_en
                     && !(ZR && bus.alloc_addr == '0);

  // Alloc is applied last: it belongs to the newer instruction.
  always_comb begin
    pend_d = pend_q;
    if (w0_eff) pend_d[bus.w0_addr] = 1'b0;
    if (w1_eff) pend_d[bus.w1_addr] = 1'b0;
    if (alloc_eff) pend_d[bus.alloc_addr] = 1'b1;
  end

  always_comb begin
    tr_valid_d = {w1_eff, w0_eff};
    tr_addr_d  = {bus.w1_addr, bus.w0_addr};
    tr_data_d  = {bus.w1_data, bus.w0_data};
    tr_pc_d    = {bus.w1_pc, bus.w0_pc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q     <= '0;
      tr_valid_q <= '0;
      tr_addr_q  <= '0;
      tr_data_q  <= '0;
      tr_pc_q    <= '0;
    end else begin
      if (w0_eff) regs_q[bus.w0_addr] <= bus.w0_data;
      if (w1_eff) regs_q[bus.w1_addr] <= bus.w1_data;
      pend_q     <= pend_d;
      tr_valid_q <= tr_valid_d;
      tr_addr_q  <= tr_addr_d;
      tr_data_q  <= tr_data_d;
      tr_pc_q    <= tr_pc_d;
    end
  end

  assign bus.trace_valid = tr_valid_q;
  assign bus.trace_addr  = tr_addr_q;
  assign bus.trace_data  = tr_data_q;
  assign bus.trace_pc    = tr_pc_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = regs_q[a];
      b = pend_q[a];
      if (BP && w1_eff && bus.w1_addr == a) begin
        d = bus.w1_data;
        b = alloc_eff && bus.alloc_addr == a;
      end else if (BP && w0_eff && bus.w0_addr == a) begin
        d = bus.w0_data;
        b = alloc_eff && bus.alloc_addr == a;
      end
      if (ZR && a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = d;
    assign bus.rd_busy[k] = b;
  end
endmodule

// File: tb/tb_gpr_file_mp.sv
// Scoreboard bench for gpr_file_mp: directed vectors push expectations,
// monitors pop and compare read results and trace pulses.
module tb_gpr_file_mp;
  logic clk;
  logic reset;

  gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  gpr_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2),
    .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       nm;
    int          kind;
    int          p;
    logic [31:0] d;
    logic        b;
  } rexp_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } texp_t;

  rexp_t rq[$];
  texp_t tq0[$];
  texp_t tq1[$];
  event  sample_ev;
  int    total = 0;
  int    bad = 0;

  // Read/flag monitor
  initial begin
    forever begin
      @(sample_ev);
      while (rq.size() > 0) begin
        rexp_t e;
        logic [31:0] ad;
        logic ab;
        e = rq.pop_front();
        if (e.kind == 0) begin
          ad = bus.rd_data[e.p*32 +: 32];
          ab = bus.rd_busy[e.p];
        end else begin
          ad = {30'b0, bus.trace_valid};
          ab = 1'b0;
        end
        total++;
        if (ad !== e.d || ab !== e.b) begin
          bad++;
          $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b",
                   e.nm, ad, ab, e.d, e.b);
        end
      end
    end
  end

  task automatic trace_chk(input int lane, input texp_t e);
    logic [4:0]  aa;
    logic [31:0] ad, ap;
    aa = bus.trace_addr[lane*5 +: 5];
    ad = bus.trace_data[lane*32 +: 32];
    ap = bus.trace_pc[lane*32 +: 32];
    total++;
    if (aa !== e.a || ad !== e.d || ap !== e.pc) begin
      bad++;
      $display("FAIL trace%0d: got a=%0d d=%h pc=%h want a=%0d d=%h pc=%h",
               lane, aa, ad, ap, e.a, e.d, e.pc);
    end
  endtask

  // Trace monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.trace_valid[0]) begin
          if (tq0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL trace0_unexpected: got a=%0d d=%h want none",
                     bus.trace_addr[4:0], bus.trace_data[31:0]);
          end else trace_chk(0, tq0.pop_front());
        end
        if (bus.trace_valid[1]) begin
          if (tq1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL trace1_unexpected: got a=%0d d=%h want none",
                     bus.trace_addr[9:5], bus.trace_data[63:32]);
          end else trace_chk(1, tq1.pop_front());
        end
      end
    end
  end

  task automatic idle();
    bus.w0_en = 1'b0; bus.w0_addr = '0; bus.w0_data = '0; bus.w0_pc = '0;
    bus.w1_en = 1'b0; bus.w1_addr = '0; bus.w1_data = '0; bus.w1_pc = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] pc, input bit exp);
    texp_t t;
    bus.w0_en = 1'b1; bus.w0_addr = a; bus.w0_data = d; bus.w0_pc = pc;
    t.a = a; t.d = d; t.pc = pc;
    if (exp) tq0.push_back(t);
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] pc, input bit exp);
    texp_t t;
    bus.w1_en = 1'b1; bus.w1_addr = a; bus.w1_data = d; bus.w1_pc = pc;
    t.a = a; t.d = d; t.pc = pc;
    if (exp) tq1.push_back(t);
  endtask

  task automatic rd(input string nm, input int p, input logic [4:0] a,
                    input logic [31:0] d, input logic b);
    rexp_t e;
    bus.rd_addr[p*5 +: 5] = a;
    #1;
    e.nm = nm; e.kind = 0; e.p = p; e.d = d; e.b = b;
    rq.push_back(e);
    -> sample_ev;
    #1;
  endtask

  task automatic tv(input string nm, input logic [1:0] v);
    rexp_t e;
    e.nm = nm; e.kind = 1; e.p = 0; e.d = {30'b0, v}; e.b = 1'b0;
    rq.push_back(e);
    -> sample_ev;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  initial begin
    reset = 1'b0;
    bus.rd_addr = '0;
    idle();
    #1 reset = 1'b1;
    rd("rst_r7", 0, 5'd7, 32'h0, 1'b0);
    rd("rst_r5", 1, 5'd5, 32'h0, 1'b0);
    tv("rst_tv", 2'b00);
    @(negedge clk);
    reset = 1'b0;
    idle();

    wr0(5'd5, 32'hDEADBEEF, 32'h00003000, 1'b1);
    rd("byp_r5_p0", 0, 5'd5, 32'hDEADBEEF, 1'b0);
    rd("byp_r5_p1", 1, 5'd5, 32'hDEADBEEF, 1'b0);

    next();
    wr0(5'd7, 32'h11111111, 32'h00003004, 1'b0);
    wr1(5'd7, 32'h22222222, 32'h00003008, 1'b1);
    rd("coll_byp_r7", 0, 5'd7, 32'h22222222, 1'b0);
    rd("stored_r5", 1, 5'd5, 32'hDEADBEEF, 1'b0);

    next();
    wr1(5'd0, 32'hFFFFFFFF, 32'h0000300C, 1'b0);
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    rd("zero_byp_r0", 0, 5'd0, 32'h0, 1'b0);
    rd("coll_stored_r7", 1, 5'd7, 32'h22222222, 1'b0);

    next();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    rd("alloc_same_cyc", 0, 5'd9, 32'h0, 1'b0);

    next();
    rd("alloc_busy_r9", 0, 5'd9, 32'h0, 1'b1);
    rd("zero_stored_r0", 1, 5'd0, 32'h0, 1'b0);

    next();
    wr0(5'd9, 32'h00000005, 32'h00003010, 1'b1);
    rd("wr_clear_byp", 0, 5'd9, 32'h5, 1'b0);

    next();
    rd("wr_clear_p0", 0, 5'd9, 32'h5, 1'b0);
    rd("wr_clear_p1", 1, 5'd9, 32'h5, 1'b0);

    next();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    wr1(5'd9, 32'h00000077, 32'h00003020, 1'b1);
    rd("alloc_wr_byp", 0, 5'd9, 32'h77, 1'b1);

    next();
    rd("alloc_wr_stored", 0, 5'd9, 32'h77, 1'b1);

    next();
    wr0(5'd3, 32'hA5A5A5A5, 32'h00003030, 1'b1);

    next();
    rd("r3_stored", 0, 5'd3, 32'hA5A5A5A5, 1'b0);
    wr0(5'd3, 32'h12345678, 32'h00003034, 1'b0);
    rd("r3_inflight_byp", 1, 5'd3, 32'h12345678, 1'b0);
    reset = 1'b1;
    idle();
    rd("midrst_r3", 0, 5'd3, 32'h0, 1'b0);
    tv("midrst_tv", 2'b00);
    rd("midrst_busy_r9", 1, 5'd9, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    next();
    rd("r3_lost", 0, 5'd3, 32'h0, 1'b0);
    wr0(5'd1, 32'hCAFE0001, 32'h00003040, 1'b1);
    wr1(5'd2, 32'hCAFE0002, 32'h00003044, 1'b1);
    rd("dual_byp_r2", 1, 5'd2, 32'hCAFE0002, 1'b0);

    next();
    wr0(5'd1, 32'h0000BEEF, 32'h00003048, 1'b1);
    rd("b2b_byp_r1", 0, 5'd1, 32'h0000BEEF, 1'b0);

    next();
    rd("dual_stored_r2", 1, 5'd2, 32'hCAFE0002, 1'b0);

    next();
    next();
    total++;
    if (tq0.size() != 0 || tq1.size() != 0) begin
      bad++;
      $display("FAIL trace_missing: got pending lane0=%0d lane1=%0d want 0",
               tq0.size(), tq1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
